alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 21 ++
 rtl/mul_seq.sv | 52 +++++
 rtl/alu_exec_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit op codes (also consumed by ALU control)
// and the execute-unit FSM state encoding.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b1100;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per step.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : latch a/b, clear counter and accumulator
//   step          : process multiplier bit [cnt] this edge
//   abort         : drop the in-flight multiply
//   a, b          : multiplicand / multiplier
//   done          : comb, high on the step that consumes bit 31
//   product       : comb, final low-32 product, valid when done
module mul_seq
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  logic [4:0]      cnt;
  logic [XLEN-1:0] acc, ma, mb, acc_nxt;

  // Partial product truncated to 32 bits, so the sum is the low word.
  assign acc_nxt = acc + (mb[cnt] ? (ma << cnt) : '0);
  assign done    = step && (cnt == 5'd31);
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ma  <= '0;
      mb  <= '0;
    end else if (start) begin
      cnt <= '0;
      acc <= '0;
      ma  <= a;
      mb  <= b;
    end else if (abort) begin
      cnt <= '0;
      acc <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      cnt <= cnt + 5'd1;  // wraps to 0 after the final bit
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus a 32-cycle
// sequential multiply. Results are registered; out_valid pulses per result.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid / in_ready    : operation handshake (ready low while multiplying)
//   alu_ctrl, op_a, op_b   : op code and operands
//   flush                  : kill in-flight op / suppress acceptance
//   out_valid              : one-cycle pulse, new result registered
//   out_result, out_zero   : registered result and its zero flag
//   busy                   : ~in_ready, stall request to hazard unit
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            busy
);

  exec_state_t     state, state_nxt;
  logic            accept, is_mul;
  logic            mul_start, mul_step, mul_abort, mul_done;
  logic [XLEN-1:0] mul_res, alu_res;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = ~in_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign is_mul    = (alu_ctrl == ALU_MUL);
  assign mul_start = accept && is_mul;
  assign mul_step  = (state == ST_MUL) && !flush;
  assign mul_abort = (state == ST_MUL) && flush;

  mul_seq u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .step    (mul_step),
    .abort   (mul_abort),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_res)
  );

  // Single-cycle datapath; unlisted codes (and MUL here) give zero.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: alu_res = op_a + op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_SLL: alu_res = op_a << op_b[4:0];
      ALU_SRL: alu_res = op_a >> op_b[4:0];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start)         state_nxt = ST_MUL;
      ST_MUL:  if (flush || mul_done) state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  // mul_done is already gated by !flush, so flush wins on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        out_valid  <= 1'b1;
        out_result <= alu_res;
        out_zero   <= (alu_res == '0);
      end else if (mul_done) begin
        out_valid  <= 1'b1;
        out_result <= mul_res;
        out_zero   <= (mul_res == '0);
      end
    end
  end

endmodule
